// File: rtl/aes_subbytes_seq_dom.sv
// Byte-serial SubBytes sequencer feeding a pipelined DOM masked S-box and
// reassembling the substituted state. Optional macro: SUBBYTES_ZEROIZE_EN.
module aes_subbytes_seq_dom #(
    parameter int d        = 2,
    parameter int SBOX_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [128*d-1:0]     state_in,
    output logic                 busy,
    output logic                 done,
    output logic [128*d-1:0]     state_out,
    output logic [8*d-1:0]       sbox_in,
    output logic                 rnd_req,
    input  logic [8*d-1:0]       sbox_out
);

    localparam int BW = 8 * d;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_r;
    logic [128*d-1:0]    in_reg_r;
    logic [128*d-1:0]    state_out_r;
    logic [BW-1:0]       sbox_in_r;
    logic [3:0]          issue_cnt_r;
    logic [3:0]          cap_cnt_r;
    logic [SBOX_LAT-1:0] vld_sr_r;
    logic                busy_r;
    logic                done_r;
    logic                rnd_req_r;
    logic [3:0]          next_issue_s;
    logic                cap_s;

    assign next_issue_s = issue_cnt_r + 4'd1;
    // Tap marks the cycle in which the byte issued SBOX_LAT cycles ago is on sbox_out.
    assign cap_s        = vld_sr_r[SBOX_LAT-1];

    assign busy      = busy_r;
    assign done      = done_r;
    assign state_out = state_out_r;
    assign sbox_in   = sbox_in_r;
    assign rnd_req   = rnd_req_r;

    // Sequencer FSM, in-flight tracking, result capture and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_reg_r    <= {(128*d){1'b0}};
            state_out_r <= {(128*d){1'b0}};
            sbox_in_r   <= {BW{1'b0}};
            issue_cnt_r <= 4'd0;
            cap_cnt_r   <= 4'd0;
            vld_sr_r    <= {SBOX_LAT{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            rnd_req_r   <= 1'b0;
        end else begin
            vld_sr_r[0] <= rnd_req_r;
            for (int i = 1; i < SBOX_LAT; i++) begin
                vld_sr_r[i] <= vld_sr_r[i-1];
            end

            if (cap_s) begin
                state_out_r[cap_cnt_r*BW +: BW] <= sbox_out;
                if (cap_cnt_r != 4'd15) begin
                    cap_cnt_r <= cap_cnt_r + 4'd1;
                end else begin
                    cap_cnt_r <= cap_cnt_r;
                end
            end else begin
                cap_cnt_r <= cap_cnt_r;
            end

            case (state_r)
                IDLE: begin
                    if (start) begin
                        in_reg_r    <= state_in;
                        sbox_in_r   <= state_in[BW-1:0];
                        rnd_req_r   <= 1'b1;
                        busy_r      <= 1'b1;
                        issue_cnt_r <= 4'd0;
                        cap_cnt_r   <= 4'd0;
`ifdef SUBBYTES_ZEROIZE_EN
                        state_out_r <= {(128*d){1'b0}};
`endif
                        state_r     <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
`ifdef SUBBYTES_ZEROIZE_EN
                    in_reg_r[issue_cnt_r*BW +: BW] <= {BW{1'b0}};
`endif
                    // Count holds at 15 so it never wraps inside one operation.
                    if (issue_cnt_r == 4'd15) begin
                        sbox_in_r <= {BW{1'b0}};
                        rnd_req_r <= 1'b0;
                        state_r   <= DRAIN;
                    end else begin
                        issue_cnt_r <= next_issue_s;
                        sbox_in_r   <= in_reg_r[next_issue_s*BW +: BW];
                        state_r     <= ISSUE;
                    end
                end
                DRAIN: begin
                    if (cap_s && (cap_cnt_r == 4'd15)) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    rnd_req_r <= 1'b0;
                    sbox_in_r <= {BW{1'b0}};
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_subbytes_seq_dom.sv
// Scoreboard bench for aes_subbytes_seq_dom with a behavioural masked S-box.
`timescale 1ns/1ps
module tb_aes_subbytes_seq_dom;

    localparam int D     = 2;
    localparam int LAT   = 4;
    localparam int BW    = 8 * D;
    localparam int OPLEN = 17 + LAT;

    typedef struct packed {
        logic [127:0] exp;
        logic [31:0]  done_cyc;
    } sb_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [128*D-1:0]  state_in;
    logic              busy;
    logic              done;
    logic [128*D-1:0]  state_out;
    logic [BW-1:0]     sbox_in;
    logic              rnd_req;
    logic [BW-1:0]     sbox_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    sb_t sb_q[$];
    logic [BW-1:0] pipe [LAT];
    logic [7:0] row0 [16] = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
                              8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76};

    aes_subbytes_seq_dom #(.d(D), .SBOX_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .state_in(state_in),
        .busy(busy), .done(done), .state_out(state_out),
        .sbox_in(sbox_in), .rnd_req(rnd_req), .sbox_out(sbox_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        if (x[7:4] == 4'h0) return row0[x[3:0]];
        else if (x == 8'h53) return 8'hed;
        else return 8'h00;
    endfunction

    function automatic logic [BW-1:0] mask2(input logic [7:0] v, input logic [7:0] m);
        logic [BW-1:0] f;
        for (int j = 0; j < 8; j++) begin
            f[j*D]   = v[j] ^ m[j];
            f[j*D+1] = m[j];
        end
        return f;
    endfunction

    function automatic logic [7:0] unmask(input logic [BW-1:0] f);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[j] = ^f[j*D +: D];
        return b;
    endfunction

    initial for (int i = 0; i < LAT; i++) pipe[i] = '0;

    // Environment S-box: fixed latency, fresh output mask each cycle.
    always @(posedge clk) begin
        pipe[0] <= mask2(sbox_ref(unmask(sbox_in)), 8'($urandom()));
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign sbox_out = pipe[LAT-1];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected result whenever the DUT reports done.
    always @(negedge clk) begin
        sb_t e;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("done_cycle", 256'(cyc), 256'(e.done_cyc));
                for (int k = 0; k < 16; k++)
                    chk($sformatf("result_byte%0d", k), 256'(unmask(state_out[k*BW +: BW])),
                        256'(e.exp[k*8 +: 8]));
            end
        end
    end

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"}, 256'(busy), 256'(0));
        chk({tag, "_done"}, 256'(done), 256'(0));
        chk({tag, "_rnd_req"}, 256'(rnd_req), 256'(0));
        chk({tag, "_sbox_in"}, 256'(sbox_in), 256'(0));
        chk({tag, "_state_out"}, 256'(state_out), 256'(0));
    endtask

    task automatic run_op(input logic [127:0] vals, input logic [127:0] masks,
                          input logic [127:0] exp, input int wait_exp,
                          input bit hold, input bit poke, input bit abort);
        logic [128*D-1:0] st;
        int w;
        int acc;
        for (int k = 0; k < 16; k++) st[k*BW +: BW] = mask2(vals[k*8 +: 8], masks[k*8 +: 8]);
        state_in = st;
        start    = 1'b1;
        w        = 0;
        while (w < 6) begin
            @(negedge clk);
            w++;
            if (busy === 1'b1) break;
        end
        chk("accept_wait", 256'(w), 256'(wait_exp));
        if (busy !== 1'b1) begin
            start = 1'b0;
            return;
        end
        acc = cyc;
        if (!abort) sb_q.push_back('{exp, 32'(acc + 16 + LAT)});
        state_in = {8{$urandom()}};
        for (int n = 1; n <= OPLEN; n++) begin
            if (n > 1) @(negedge clk);
            if (n == 1 && !hold) start = 1'b0;
            if (poke && (n == 5 || n == 20)) start = 1'b1;
            if (poke && (n == 6 || n == 21)) start = 1'b0;
`ifdef SUBBYTES_ZEROIZE_EN
            if (n == 1) chk("zeroize_out", 256'(state_out), 256'(0));
`endif
            if (abort && n == 10) begin
                rst = 1'b1;
                @(negedge clk);
                chk_reset_outs("abort");
                rst = 1'b0;
                return;
            end
            chk($sformatf("rnd_req_c%0d", n), 256'(rnd_req), 256'(n <= 16));
            chk($sformatf("busy_c%0d", n), 256'(busy), 256'(n <= 16 + LAT));
            chk($sformatf("done_c%0d", n), 256'(done), 256'(n == OPLEN));
            chk($sformatf("sbox_in_c%0d", n), 256'(sbox_in),
                256'((n <= 16) ? st[(n-1)*BW +: BW] : {BW{1'b0}}));
        end
        if (!hold) start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] v_zero, e_zero, v2, m2, e2, v3, m3, e3;
        rst      = 1'b1;
        start    = 1'b0;
        state_in = {8{$urandom()}};
        repeat (3) begin
            @(negedge clk);
            chk_reset_outs("reset");
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk_reset_outs("idle");
        end

        v_zero = '0;
        e_zero = {16{8'h63}};
        for (int k = 0; k < 16; k++) begin
            v2[k*8 +: 8] = 8'(k);
            m2[k*8 +: 8] = 8'($urandom());
            e2[k*8 +: 8] = row0[k];
            v3[k*8 +: 8] = 8'(15 - k);
            m3[k*8 +: 8] = 8'($urandom());
            e3[k*8 +: 8] = row0[15-k];
        end
        v2[7:0]  = 8'h53; m2[7:0]  = 8'ha5; e2[7:0]  = 8'hed;
        v2[15:8] = 8'h00; m2[15:8] = 8'h3c; e2[15:8] = 8'h63;

        run_op(v_zero, v_zero, e_zero, 1, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        run_op(v2, m2, e2, 1, 1'b0, 1'b1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("post_poke_busy", 256'(busy), 256'(0));
        end

        run_op(v3, m3, e3, 1, 1'b1, 1'b0, 1'b0);
        run_op(v2, m2, e2, 2, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        run_op(v3, m3, e3, 1, 1'b0, 1'b0, 1'b1);
        repeat (2) begin
            @(negedge clk);
            chk_reset_outs("post_abort");
        end
        run_op(v3, m2, e3, 1, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 256'(sb_q.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
